instruction_sequencer: RTL

Front-end stage of the accelerator: holds a BUFFER_LEN-entry instruction buffer loaded by the host, and on `ce` walks it from address 0. Each 24-bit word is decoded into opcode/operand fields and handed to the execute stage (memory + compute grid) over a valid/ready issue port. Sequencing stops on a HALT opcode or at the end of the buffer, and `done` is raised.

---
 rtl/instruction_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - instruction buffer, fetch/decode and issue sequencer
//
// Front-end stage of the accelerator. The host loads a BUFFER_LEN-entry instruction
// buffer. While ce is high the sequencer walks the buffer from address 0, decodes
// each 24-bit word and hands it to the execute stage over a valid/ready issue port.
// Sequencing ends on a HALT opcode (63) or after the last buffer entry, and done is raised.
//
// Optional feature macro: SEQ_SKIP_NOP_EN
//   defined   - NOP words (opcode 0) are consumed in FETCH at one cycle each, never issued
//   undefined - NOP words are issued like any other opcode and must be handshaken
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   ce                 run enable (level); low pauses FETCH, low in DONE returns to IDLE
//   load_en/addr/data  host write port into the buffer; ignored while busy
//   issue_valid/ready  issue handshake to the execute stage
//   issue_opcode       word[23:18]
//   issue_src_a        word[17:13]
//   issue_src_b        word[12:8]
//   issue_dst          word[7:3]
//   issue_mode         word[2:0]
//   pc                 current fetch address
//   busy               high in FETCH and ISSUE
//   done               high in DONE

module instruction_sequencer #(
    parameter int INSTR_WIDTH = 24,
    parameter int BUFFER_LEN  = 32,
    parameter int PC_WIDTH    = $clog2(BUFFER_LEN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   load_en,
    input  logic [PC_WIDTH-1:0]    load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [5:0]             issue_opcode,
    output logic [4:0]             issue_src_a,
    output logic [4:0]             issue_src_b,
    output logic [4:0]             issue_dst,
    output logic [2:0]             issue_mode,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_DONE
    } state_t;

    localparam logic [5:0]          OP_HALT = 6'd63;
`ifdef SEQ_SKIP_NOP_EN
    localparam logic [5:0]          OP_NOP  = 6'd0;
`endif
    localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(BUFFER_LEN - 1);
    localparam logic [PC_WIDTH-1:0] PC_ONE  = PC_WIDTH'(1);

    // Instruction buffer: host-loaded only, deliberately not cleared by reset so a
    // program survives a reset and can simply be rerun.
    logic [INSTR_WIDTH-1:0] buf_q [BUFFER_LEN];

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic                   valid_q, valid_d;
    logic [5:0]             opcode_q, opcode_d;
    logic [4:0]             src_a_q, src_a_d;
    logic [4:0]             src_b_q, src_b_d;
    logic [4:0]             dst_q, dst_d;
    logic [2:0]             mode_q, mode_d;

    logic [INSTR_WIDTH-1:0] fetch_word;
    logic [5:0]             fetch_op;
    logic                   at_end;
    logic                   busy_w;

    assign fetch_word = buf_q[pc_q];
    assign fetch_op   = fetch_word[23:18];
    assign at_end     = (pc_q == LAST_PC);
    assign busy_w     = (state_q == S_FETCH) || (state_q == S_ISSUE);

    // Host writes land only while idle or done; a write on the same edge that ce
    // starts a run still lands because the state is IDLE at that edge.
    always_ff @(posedge clk) begin
        if (load_en && !busy_w) begin
            buf_q[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            valid_q  <= 1'b0;
            opcode_q <= '0;
            src_a_q  <= '0;
            src_b_q  <= '0;
            dst_q    <= '0;
            mode_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            src_a_q  <= src_a_d;
            src_b_q  <= src_b_d;
            dst_q    <= dst_d;
            mode_q   <= mode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        opcode_d = opcode_q;
        src_a_d  = src_a_q;
        src_b_d  = src_b_q;
        dst_d    = dst_q;
        mode_d   = mode_q;

        unique case (state_q)
            S_IDLE: begin
                if (ce) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                // ce low simply freezes the walk at the current pc.
                if (ce) begin
                    if (fetch_op == OP_HALT) begin
                        state_d = S_DONE;
`ifdef SEQ_SKIP_NOP_EN
                    end else if (fetch_op == OP_NOP) begin
                        if (at_end) begin
                            state_d = S_DONE;
                        end else begin
                            pc_d = pc_q + PC_ONE;
                        end
`endif
                    end else begin
                        opcode_d = fetch_word[23:18];
                        src_a_d  = fetch_word[17:13];
                        src_b_d  = fetch_word[12:8];
                        dst_d    = fetch_word[7:3];
                        mode_d   = fetch_word[2:0];
                        valid_d  = 1'b1;
                        state_d  = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                // The issued instruction is owed to the execute stage, so ce is
                // ignored here; only the handshake moves things on.
                if (valid_q && issue_ready) begin
                    valid_d = 1'b0;
                    if (at_end) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_q + PC_ONE;
                        state_d = S_FETCH;
                    end
                end
            end

            S_DONE: begin
                if (!ce) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign issue_valid  = valid_q;
    assign issue_opcode = opcode_q;
    assign issue_src_a  = src_a_q;
    assign issue_src_b  = src_b_q;
    assign issue_dst    = dst_q;
    assign issue_mode   = mode_q;
    assign pc           = pc_q;
    assign busy         = busy_w;
    assign done         = (state_q == S_DONE);

endmodule
